// File: rtl/imem_uart_loader.sv
// UART program loader: receives a length-prefixed image over 8N1 serial and writes it word by word into instruction memory.
// Build option IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check (CHK state).
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx,
  output logic                  prog_active,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [15:0]           word_count,
  output logic                  done,
  output logic                  err
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]   DEPTH     = 17'(1) << ADDR_WIDTH;

  // Sync flops reset high so a start held high through reset release is not seen as an edge.
  logic rx_s1, rx_s, start_s1, start_s2, start_q, start_edge;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1; rx_s <= 1'b1;
      start_s1 <= 1'b1; start_s2 <= 1'b1; start_q <= 1'b1;
    end else begin
      rx_s1 <= rx; rx_s <= rx_s1;
      start_s1 <= start; start_s2 <= start_s1; start_q <= start_s2;
    end
  end
  assign start_edge = start_s2 & ~start_q;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  rx_state_t r_state, r_next;
  logic [TW-1:0] timer, t_next;
  logic [2:0] bit_cnt, b_next;
  logic [7:0] rx_byte, sh_next;
  logic byte_valid, bv_next, frame_err, fe_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE; timer <= '0; bit_cnt <= '0; rx_byte <= '0;
      byte_valid <= 1'b0; frame_err <= 1'b0;
    end else begin
      r_state <= r_next; timer <= t_next; bit_cnt <= b_next; rx_byte <= sh_next;
      byte_valid <= bv_next; frame_err <= fe_next;
    end
  end

  always_comb begin
    r_next = r_state; t_next = timer; b_next = bit_cnt; sh_next = rx_byte;
    bv_next = 1'b0; fe_next = 1'b0;
    case (r_state)
      R_IDLE: if (!rx_s) begin r_next = R_START; t_next = HALF_LAST; end
      R_START:
        if (timer == '0) begin
          if (!rx_s) begin r_next = R_DATA; t_next = BIT_LAST; b_next = '0; end
          else r_next = R_IDLE;
        end else t_next = timer - TW'(1);
      R_DATA:
        if (timer == '0) begin
          sh_next = {rx_s, rx_byte[7:1]};
          t_next  = BIT_LAST;
          if (bit_cnt == 3'd7) r_next = R_STOP;
          else b_next = bit_cnt + 3'd1;
        end else t_next = timer - TW'(1);
      R_STOP:
        if (timer == '0) begin
          r_next = R_IDLE;
          if (rx_s) bv_next = 1'b1;
          else fe_next = 1'b1;
        end else t_next = timer - TW'(1);
      default: r_next = R_IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CHK, DONE, ERR} ld_state_t;
  localparam ld_state_t AFTER_DATA = CHK;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE, ERR} ld_state_t;
  localparam ld_state_t AFTER_DATA = DONE;
`endif
  ld_state_t state, nxt;
  logic [15:0] n_cnt, n_full;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0] byte_idx;
  logic [23:0] word_buf;
  logic load_ok, last_word;

  assign load_ok     = (state == IDLE) || (state == DONE) || (state == ERR);
  assign n_full      = {rx_byte, n_cnt[7:0]};
  assign last_word   = (byte_idx == 2'd3) && (word_count + 16'd1 == n_cnt);
  assign prog_active = !load_ok;
  assign done        = (state == DONE);
  assign err         = (state == ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start_edge) nxt = HDR0;
      HDR0: if (frame_err) nxt = ERR; else if (byte_valid) nxt = HDR1;
      HDR1:
        if (frame_err) nxt = ERR;
        else if (byte_valid) begin
          if ({1'b0, n_full} > DEPTH) nxt = ERR;
          else if (n_full == 16'd0)   nxt = AFTER_DATA;
          else                        nxt = DATA;
        end
      DATA: if (frame_err) nxt = ERR; else if (byte_valid && last_word) nxt = AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:
        if (frame_err) nxt = ERR;
        else if (byte_valid) nxt = (rx_byte == csum) ? DONE : ERR;
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_we <= 1'b0; imem_addr <= '0; imem_wdata <= '0; word_count <= '0;
      n_cnt <= '0; addr <= '0; byte_idx <= '0; word_buf <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (load_ok && start_edge) begin
        word_count <= '0; addr <= '0; byte_idx <= '0; n_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= '0;
`endif
      end else if (byte_valid) begin
        case (state)
          HDR0: n_cnt[7:0]  <= rx_byte;
          HDR1: n_cnt[15:8] <= rx_byte;
          DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ rx_byte;
`endif
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_byte;
              2'd1: word_buf[15:8]  <= rx_byte;
              2'd2: word_buf[23:16] <= rx_byte;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= addr;
                imem_wdata <= {rx_byte, word_buf};
                addr       <= addr + 1'b1;
                word_count <= word_count + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader: expected writes are queued by the stimulus and checked by a write monitor.
module tb_imem_uart_loader;
  localparam int CPB = 4;
  localparam int AW  = 4;

  logic clk, rst, start, rx;
  logic prog_active, imem_we, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] word_count;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx(rx),
    .prog_active(prog_active), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .word_count(word_count), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int writes_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        wr_t e;
        writes_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(imem_addr), 32'(e.a));
          check("write_data", imem_wdata, e.d);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(done || err) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done/err expected done or err within 500 cycles", name);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_flags"}, {28'd0, prog_active, imem_we, done, err}, 32'd0);
    check({name, "_addr"}, 32'(imem_addr), 32'd0);
    check({name, "_wdata"}, imem_wdata, 32'd0);
    check({name, "_wcount"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    int w0;
    rst = 1'b0; start = 1'b0; rx = 1'b1;

    // 1: reset holds everything at zero even with rx activity
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rx = ~rx;
    end
    check_idle_outputs("t1_in_reset");
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check_idle_outputs("t1_after_release");
    check("t1_no_writes", 32'(writes_seen), 32'd0);

    // 2: two-word image
    pulse_start();
    check("t2_busy", 32'(prog_active), 32'd1);
    exp_q.push_back('{a: 4'd0, d: 32'h1234_5678});
    exp_q.push_back('{a: 4'd1, d: 32'hDEAD_BEEF});
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h2A, 1'b1);
`endif
    wait_end("t2");
    check("t2_done", 32'(done), 32'd1);
    check("t2_err", 32'(err), 32'd0);
    check("t2_wcount", 32'(word_count), 32'd2);
    check("t2_prog_active", 32'(prog_active), 32'd0);
    check("t2_writes", 32'(writes_seen), 32'd2);

    // 3: framing error on the third data byte discards the partial word
    w0 = writes_seen;
    pulse_start();
    check("t3_done_cleared", 32'(done), 32'd0);
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b0);
    wait_end("t3");
    check("t3_err", 32'(err), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_prog_active", 32'(prog_active), 32'd0);
    check("t3_writes", 32'(writes_seen - w0), 32'd0);
    pulse_start();
    check("t3_err_cleared", 32'(err), 32'd0);
    check("t3_restart_busy", 32'(prog_active), 32'd1);

    // 4a: zero-length image completes without writes
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    wait_end("t4a");
    check("t4a_done", 32'(done), 32'd1);
    check("t4a_err", 32'(err), 32'd0);
    check("t4a_wcount", 32'(word_count), 32'd0);
    check("t4a_writes", 32'(writes_seen - w0), 32'd0);

    // 4b: N=17 exceeds depth 16
    pulse_start();
    send_byte(8'h11, 1'b1); send_byte(8'h00, 1'b1);
    wait_end("t4b");
    check("t4b_err", 32'(err), 32'd1);
    check("t4b_done", 32'(done), 32'd0);
    check("t4b_writes", 32'(writes_seen - w0), 32'd0);

    // 5: reset mid-word, then a fresh load starts at address 0
    pulse_start();
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    rst = 1'b0;
    #1;
    check_idle_outputs("t5_async_reset");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_writes_during_abort", 32'(writes_seen - w0), 32'd0);
    pulse_start();
    exp_q.push_back('{a: 4'd0, d: 32'h1122_3344});
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h44, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h11, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h44, 1'b1);
`endif
    wait_end("t5");
    check("t5_done", 32'(done), 32'd1);
    check("t5_wcount", 32'(word_count), 32'd1);
    check("t5_writes", 32'(writes_seen - w0), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: checksum good then bad; the word is written both times
    pulse_start();
    exp_q.push_back('{a: 4'd0, d: 32'h0804_0201});
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h08, 1'b1);
    send_byte(8'h0F, 1'b1);
    wait_end("t6a");
    check("t6a_done", 32'(done), 32'd1);
    check("t6a_err", 32'(err), 32'd0);
    pulse_start();
    exp_q.push_back('{a: 4'd0, d: 32'h0804_0201});
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h08, 1'b1);
    send_byte(8'h0E, 1'b1);
    wait_end("t6b");
    check("t6b_err", 32'(err), 32'd1);
    check("t6b_done", 32'(done), 32'd0);
    check("t6b_wcount", 32'(word_count), 32'd1);
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
